// File: rtl/gated_clk_pkg.sv
// Shared state encodings and sizing helper for the clock-gating controller.
package gated_clk_pkg;
  typedef enum logic [1:0] {
    ST_ON   = 2'b00,
    ST_HOLD = 2'b01,
    ST_OFF  = 2'b10
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/gated_clk_chan.sv
// One gating channel: ON/HOLD/OFF FSM with idle hold-off, plus a saturating
// counter of cycles spent in OFF.
module gated_clk_chan
  import gated_clk_pkg::*;
#(
  parameter int HOLD_CYC = 3,
  parameter int CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_b_i,
  input  logic             req_i,
  input  logic             scan_en_i,
  input  logic             stat_clr_i,
  output logic             clk_en_o,
  output logic             off_o,
  output logic [CNT_W-1:0] cnt_o
);
  localparam int HW = (clog2(HOLD_CYC + 1) < 1) ? 1 : clog2(HOLD_CYC + 1);
  localparam logic [HW-1:0] HLOAD = (HOLD_CYC > 0) ? HW'(HOLD_CYC - 1) : '0;

  state_e           state_q;
  logic [HW-1:0]    hcnt_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_b_i) begin
      state_q <= ST_ON;
      hcnt_q  <= '0;
    end else begin
      case (state_q)
        ST_ON: begin
          if (!req_i) begin
            if (HOLD_CYC == 0) begin
              state_q <= ST_OFF;
            end else begin
              state_q <= ST_HOLD;
              hcnt_q  <= HLOAD;
            end
          end
        end
        // A returning request beats expiry of the hold-off.
        ST_HOLD: begin
          if (req_i)              state_q <= ST_ON;
          else if (hcnt_q == '0)  state_q <= ST_OFF;
          else                    hcnt_q  <= hcnt_q - HW'(1);
        end
        ST_OFF: begin
          if (req_i) state_q <= ST_ON;
        end
        default: state_q <= ST_ON;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_b_i || stat_clr_i)                 cnt_q <= '0;
    else if (state_q == ST_OFF && cnt_q != '1)  cnt_q <= cnt_q + 1'b1;
  end

  assign off_o    = (state_q == ST_OFF);
  assign clk_en_o = !off_o || scan_en_i;
  assign cnt_o    = cnt_q;
endmodule

// File: rtl/gated_clk_ctrl_multi.sv
// Multi-channel clock-gating controller: builds per-channel requests, runs one
// gated_clk_chan per channel, and exposes enables, counters and all-gated status.
module gated_clk_ctrl_multi #(
  parameter int CH_NUM   = 4,
  parameter int HOLD_CYC = 3,
  parameter int CNT_W    = 16
) (
  input  logic                    forever_cpuclk,
  input  logic                    cpurst_b,
  input  logic                    global_en,
  input  logic [CH_NUM-1:0]       module_en,
  input  logic [CH_NUM-1:0]       local_en,
  input  logic [CH_NUM-1:0]       external_en,
  input  logic                    pad_yy_icg_scan_en,
  input  logic                    stat_clr,
  output logic [CH_NUM-1:0]       clk_en,
  output logic [CH_NUM-1:0]       clk_out,
  output logic [CH_NUM*CNT_W-1:0] gated_cnt,
  output logic                    all_gated
);
  logic [CH_NUM-1:0] req;
  logic [CH_NUM-1:0] off;

  assign req = ({CH_NUM{global_en}} & (module_en | local_en))
             | external_en | {CH_NUM{pad_yy_icg_scan_en}};

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    gated_clk_chan #(
      .HOLD_CYC (HOLD_CYC),
      .CNT_W    (CNT_W)
    ) u_chan (
      .clk_i      (forever_cpuclk),
      .rst_b_i    (cpurst_b),
      .req_i      (req[i]),
      .scan_en_i  (pad_yy_icg_scan_en),
      .stat_clr_i (stat_clr),
      .clk_en_o   (clk_en[i]),
      .off_o      (off[i]),
      .cnt_o      (gated_cnt[i*CNT_W +: CNT_W])
    );
  end

  // Downstream flops consume clk_en; the clock itself is never gated here.
  assign clk_out   = {CH_NUM{forever_cpuclk}};
  assign all_gated = (&off) & ~pad_yy_icg_scan_en;
endmodule
